// File: rtl/fft_bfly_scheduler_if.sv
// Handshake/bus bundle between the FFT scheduler and its control, RAM, ROM and butterfly.
// FFT_SCHED_CHK_EN adds the sticky err flag.
interface fft_bfly_scheduler_if #(
    parameter int unsigned LOG2N = 8
);
    logic             start;
    logic             busy;
    logic             done;
    logic [3:0]       stage;
    logic             rd_en;
    logic [LOG2N-1:0] rd_addr_p;
    logic [LOG2N-1:0] rd_addr_q;
    logic [LOG2N-2:0] tw_addr;
    logic             bf_en;
    logic             bf_valid;
    logic             wr_en;
    logic [LOG2N-1:0] wr_addr_p;
    logic [LOG2N-1:0] wr_addr_q;
`ifdef FFT_SCHED_CHK_EN
    logic             err;
`endif

    // Control/datapath side: drives start and the butterfly valid.
    modport master (
`ifdef FFT_SCHED_CHK_EN
        input  err,
`endif
        output start,
        output bf_valid,
        input  busy,
        input  done,
        input  stage,
        input  rd_en,
        input  rd_addr_p,
        input  rd_addr_q,
        input  tw_addr,
        input  bf_en,
        input  wr_en,
        input  wr_addr_p,
        input  wr_addr_q
    );

    // Scheduler side.
    modport slave (
`ifdef FFT_SCHED_CHK_EN
        output err,
`endif
        input  start,
        input  bf_valid,
        output busy,
        output done,
        output stage,
        output rd_en,
        output rd_addr_p,
        output rd_addr_q,
        output tw_addr,
        output bf_en,
        output wr_en,
        output wr_addr_p,
        output wr_addr_q
    );
endinterface

// File: rtl/fft_bfly_scheduler.sv
// In-place radix-2 DIT FFT sequencer: one butterfly per cycle, stages separated by a full drain.
// Optional FFT_SCHED_CHK_EN adds a sticky err output checking butterfly valid alignment.
module fft_bfly_scheduler #(
    parameter int unsigned LOG2N  = 8,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned BF_LAT = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    fft_bfly_scheduler_if.slave bus
);
    localparam int unsigned KW        = LOG2N - 1;
    localparam int unsigned LAT       = RD_LAT + BF_LAT;
    localparam logic [3:0]  LastStage = 4'(LOG2N - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e           state_q, state_d;
    logic [3:0]       stage_q, stage_d;
    logic [KW-1:0]    k_q, k_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             rd_en_q, rd_en_d;
    logic [LOG2N-1:0] rd_p_q, rd_p_d;
    logic [LOG2N-1:0] rd_q_q, rd_q_d;
    logic [KW-1:0]    tw_q, tw_d;
    logic [LOG2N-1:0] outs_q, outs_d;

    logic             bf_en_dly_q [RD_LAT];
    logic             bf_en_dly_d [RD_LAT];
    logic [LOG2N-1:0] p_dly_q [LAT];
    logic [LOG2N-1:0] p_dly_d [LAT];
    logic [LOG2N-1:0] q_dly_q [LAT];
    logic [LOG2N-1:0] q_dly_d [LAT];

    // Butterfly addressing for index k within stage s (span = 1 << s).
    logic [LOG2N-1:0] k_ext, span, k_lo, k_hi, p_addr, q_addr;
    logic [3:0]       tw_shift;
    logic [KW-1:0]    tw_addr_c;

    always_comb begin
        k_ext     = {1'b0, k_q};
        span      = LOG2N'(1) << stage_q;
        k_lo      = k_ext & (span - LOG2N'(1));
        k_hi      = (k_ext >> stage_q) << (stage_q + 4'd1);
        p_addr    = k_hi | k_lo;
        q_addr    = p_addr + span;
        tw_shift  = LastStage - stage_q;
        tw_addr_c = KW'(k_lo << tw_shift);
    end

    // Issued reads minus completed writes; a stage may only end once this drains to zero.
    always_comb begin
        outs_d = outs_q;
        if (rd_en_q && !bus.bf_valid) begin
            outs_d = outs_q + LOG2N'(1);
        end else if (!rd_en_q && bus.bf_valid && outs_q != '0) begin
            outs_d = outs_q - LOG2N'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        k_d     = k_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rd_en_d = 1'b0;
        rd_p_d  = rd_p_q;
        rd_q_d  = rd_q_q;
        tw_d    = tw_q;
        unique case (state_q)
            StIdle: begin
                stage_d = '0;
                if (bus.start) begin
                    state_d = StRun;
                    k_d     = '0;
                end
            end
            StRun: begin
                busy_d  = 1'b1;
                rd_en_d = 1'b1;
                rd_p_d  = p_addr;
                rd_q_d  = q_addr;
                tw_d    = tw_addr_c;
                k_d     = k_q + KW'(1);
                if (&k_q) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (outs_d == '0) begin
                    if (stage_q == LastStage) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = StRun;
                        stage_d = stage_q + 4'd1;
                        k_d     = '0;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                stage_d = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bf_en_dly_d[0] = rd_en_q;
        for (int i = 1; i < int'(RD_LAT); i++) begin
            bf_en_dly_d[i] = bf_en_dly_q[i-1];
        end
        p_dly_d[0] = rd_p_q;
        q_dly_d[0] = rd_q_q;
        for (int i = 1; i < int'(LAT); i++) begin
            p_dly_d[i] = p_dly_q[i-1];
            q_dly_d[i] = q_dly_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            stage_q <= '0;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            rd_p_q  <= '0;
            rd_q_q  <= '0;
            tw_q    <= '0;
            outs_q  <= '0;
            for (int i = 0; i < int'(RD_LAT); i++) begin
                bf_en_dly_q[i] <= 1'b0;
            end
            for (int i = 0; i < int'(LAT); i++) begin
                p_dly_q[i] <= '0;
                q_dly_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            k_q     <= k_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rd_en_q <= rd_en_d;
            rd_p_q  <= rd_p_d;
            rd_q_q  <= rd_q_d;
            tw_q    <= tw_d;
            outs_q  <= outs_d;
            for (int i = 0; i < int'(RD_LAT); i++) begin
                bf_en_dly_q[i] <= bf_en_dly_d[i];
            end
            for (int i = 0; i < int'(LAT); i++) begin
                p_dly_q[i] <= p_dly_d[i];
                q_dly_q[i] <= q_dly_d[i];
            end
        end
    end

`ifdef FFT_SCHED_CHK_EN
    // Expected butterfly valid: bf_en replayed BF_LAT cycles later.
    logic exp_dly_q [BF_LAT];
    logic exp_dly_d [BF_LAT];
    logic err_q, err_d;

    always_comb begin
        exp_dly_d[0] = bf_en_dly_q[RD_LAT-1];
        for (int i = 1; i < int'(BF_LAT); i++) begin
            exp_dly_d[i] = exp_dly_q[i-1];
        end
        err_d = err_q;
        if (bus.bf_valid && outs_q == '0) begin
            err_d = 1'b1;
        end
        if (exp_dly_q[BF_LAT-1] != bus.bf_valid) begin
            err_d = 1'b1;
        end
        if (state_q == StIdle && bus.start) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
            for (int i = 0; i < int'(BF_LAT); i++) begin
                exp_dly_q[i] <= 1'b0;
            end
        end else begin
            err_q <= err_d;
            for (int i = 0; i < int'(BF_LAT); i++) begin
                exp_dly_q[i] <= exp_dly_d[i];
            end
        end
    end

    assign bus.err = err_q;
`endif

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.stage     = stage_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr_p = rd_p_q;
    assign bus.rd_addr_q = rd_q_q;
    assign bus.tw_addr   = tw_q;
    assign bus.bf_en     = bf_en_dly_q[RD_LAT-1];
    assign bus.wr_en     = bus.bf_valid;
    assign bus.wr_addr_p = p_dly_q[LAT-1];
    assign bus.wr_addr_q = q_dly_q[LAT-1];
endmodule

// File: tb/tb_fft_bfly_scheduler.sv
// Randomised bench for fft_bfly_scheduler against a cycle-indexed schedule model.
// Define FFT_SCHED_CHK_EN to also exercise the err checker.
module tb_fft_bfly_scheduler;
    localparam int unsigned LOG2N  = 3;
    localparam int unsigned RD_LAT = 1;
    localparam int unsigned BF_LAT = 2;
    localparam int N      = 1 << LOG2N;
    localparam int L      = RD_LAT + BF_LAT;
    localparam int PERIOD = N / 2 + L + 1;
    localparam int TOTAL  = LOG2N * PERIOD;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              drop;
    logic              add;
    logic [BF_LAT-1:0] bf_pipe;

    int n_checks = 0;
    int n_pass   = 0;

    fft_bfly_scheduler_if #(.LOG2N(LOG2N)) bus ();

    fft_bfly_scheduler #(
        .LOG2N (LOG2N),
        .RD_LAT(RD_LAT),
        .BF_LAT(BF_LAT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Butterfly stand-in: en -> valid after BF_LAT cycles; drop/add perturb it on demand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bf_pipe <= '0;
        else        bf_pipe <= {bf_pipe[BF_LAT-2:0], bus.bf_en};
    end
    assign bus.bf_valid = (bf_pipe[BF_LAT-1] & ~drop) | add;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // Butterfly issued in cycle c (start accepted at cycle 0), straight from the index formulas.
    task automatic model_rd(input int c, output bit en, output int p, output int q,
                            output int tw);
        int s, k, span;
        en = 1'b0; p = 0; q = 0; tw = 0;
        if (c >= 1) begin
            s = (c - 1) / PERIOD;
            k = (c - 1) % PERIOD;
            if (s < int'(LOG2N) && k < N / 2) begin
                span = 1 << s;
                en   = 1'b1;
                p    = (k / span) * 2 * span + k % span;
                q    = p + span;
                tw   = (k % span) * ((N / 2) / span);
            end
        end
    endtask

    task automatic check_cycle(input int c);
        bit en;
        int p, q, tw, st;
        model_rd(c, en, p, q, tw);
        check("rd_en", int'(bus.rd_en), int'(en));
        if (en) begin
            check("rd_addr_p", int'(bus.rd_addr_p), p);
            check("rd_addr_q", int'(bus.rd_addr_q), q);
            check("tw_addr", int'(bus.tw_addr), tw);
        end
        model_rd(c - int'(RD_LAT), en, p, q, tw);
        check("bf_en", int'(bus.bf_en), int'(en));
        model_rd(c - L, en, p, q, tw);
        check("wr_en", int'(bus.wr_en), int'(en));
        if (en) begin
            check("wr_addr_p", int'(bus.wr_addr_p), p);
            check("wr_addr_q", int'(bus.wr_addr_q), q);
        end
        check("busy", int'(bus.busy), int'(c >= 1 && c < TOTAL));
        check("done", int'(bus.done), int'(c == TOTAL));
        st = 0;
        if (c <= TOTAL) st = (c / PERIOD < int'(LOG2N) - 1) ? c / PERIOD : int'(LOG2N) - 1;
        check("stage", int'(bus.stage), st);
`ifdef FFT_SCHED_CHK_EN
        check("err_run", int'(bus.err), 0);
`endif
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_rd_en"}, int'(bus.rd_en), 0);
        check({tag, "_bf_en"}, int'(bus.bf_en), 0);
        check({tag, "_wr_en"}, int'(bus.wr_en), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_done"}, int'(bus.done), 0);
        check({tag, "_stage"}, int'(bus.stage), 0);
        check({tag, "_rd_p"}, int'(bus.rd_addr_p), 0);
        check({tag, "_rd_q"}, int'(bus.rd_addr_q), 0);
        check({tag, "_tw"}, int'(bus.tw_addr), 0);
        check({tag, "_wr_p"}, int'(bus.wr_addr_p), 0);
        check({tag, "_wr_q"}, int'(bus.wr_addr_q), 0);
`ifdef FFT_SCHED_CHK_EN
        check({tag, "_err"}, int'(bus.err), 0);
`endif
    endtask

    // One transform; abort_c >= 0 pulls rst_n in that cycle, spur_c pulses an ignored start.
    task automatic run_model(input int abort_c, input int spur_c);
        bit aborted;
        aborted   = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 0; c <= TOTAL + 2 && !aborted; c++) begin
            if (c > 0) @(negedge clk);
            if (c == abort_c) begin
                aborted   = 1'b1;
                bus.start = 1'b0;
                rst_n     = 1'b0;
                @(posedge clk);
                #1;
                check_idle("abort");
                repeat (3) begin
                    @(negedge clk);
                    check("abort_rd_en", int'(bus.rd_en), 0);
                    check("abort_wr_en", int'(bus.wr_en), 0);
                end
                rst_n = 1'b1;
                @(negedge clk);
            end else begin
                check_cycle(c);
                bus.start = (c == spur_c || c == TOTAL);
            end
        end
        bus.start = 1'b0;
    endtask

`ifdef FFT_SCHED_CHK_EN
    // Last valid of the final stage arrives one cycle late: err must set and stay set.
    task automatic run_err();
        int c;
        bit seen;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        c    = 0;
        seen = 1'b0;
        while (!seen && c < 4 * TOTAL) begin
            drop = (c == TOTAL - 1);
            add  = (c == TOTAL);
            @(negedge clk);
            c++;
            if (bus.done) seen = 1'b1;
        end
        drop = 1'b0;
        add  = 1'b0;
        check("err_run_done", int'(seen), 1);
        check("err_set", int'(bus.err), 1);
        repeat (3) @(negedge clk);
        check("err_sticky", int'(bus.err), 1);
        check("err_idle_busy", int'(bus.busy), 0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("err_clear", int'(bus.err), 0);
        c    = 0;
        seen = 1'b0;
        while (!seen && c < 4 * TOTAL) begin
            @(negedge clk);
            c++;
            if (bus.done) seen = 1'b1;
        end
        check("clean_done", int'(seen), 1);
        check("clean_done_cycle", c, TOTAL);
        check("clean_err", int'(bus.err), 0);
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        drop      = 1'b0;
        add       = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("post_reset");
        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(3, 0)) @(negedge clk);
            run_model((r % 3 == 1) ? int'($urandom_range(20, 2)) : -1,
                      int'($urandom_range(TOTAL - 1, 0)));
        end
`ifdef FFT_SCHED_CHK_EN
        run_err();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
